// File: rtl/trig_sequencer.sv
// Delayed trigger sequencer: arbitrates masked trigger edges, waits for downstream
// valid, applies a programmable delay, fires a one-cycle pulse, then enforces holdoff.
module trig_sequencer #(
  parameter int N_SRC     = 4,
  parameter int CNT_WIDTH = 16,
  localparam int SW       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 mode_continuous,
  input  logic [N_SRC-1:0]     src_mask,
  input  logic [N_SRC-1:0]     trig_in,
  input  logic                 valid,
  input  logic [CNT_WIDTH-1:0] delay,
  input  logic [CNT_WIDTH-1:0] holdoff,
  output logic                 trig_out,
  output logic [SW-1:0]        src_id,
  output logic                 armed,
  output logic                 busy,
  output logic [31:0]          trig_count
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARMED      = 3'd1,
    WAIT_VALID = 3'd2,
    DELAY      = 3'd3,
    FIRE       = 3'd4,
    HOLDOFF    = 3'd5
  } state_t;

  state_t               state;
  state_t               next_state;
  logic [N_SRC-1:0]     trig_in_d;
  logic [N_SRC-1:0]     rise;
  logic                 any_rise;
  logic [SW-1:0]        win_idx;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 cnt_zero;

  assign rise     = trig_in & ~trig_in_d & src_mask;
  assign any_rise = |rise;
  assign cnt_zero = (cnt == {CNT_WIDTH{1'b0}});

  // Fixed-priority encoder: scanning downward lets the lowest index win.
  always_comb begin
    win_idx = {SW{1'b0}};
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rise[i]) begin
        win_idx = SW'(i);
      end else begin
        win_idx = win_idx;
      end
    end
  end

  // State register, edge-detect history and all registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      trig_in_d  <= {N_SRC{1'b1}};
      trig_out   <= 1'b0;
      src_id     <= {SW{1'b0}};
      trig_count <= 32'd0;
    end else begin
      state     <= next_state;
      trig_in_d <= trig_in;
      trig_out  <= (next_state == FIRE);
      if (state == ARMED && any_rise && !abort) begin
        src_id <= win_idx;
      end
      if (state == FIRE && !abort) begin
        trig_count <= trig_count + 32'd1;
      end
    end
  end

  // Shared delay/holdoff counter; holds the remaining cycles of the current wait.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= {CNT_WIDTH{1'b0}};
    end else begin
      case (state)
        ARMED:      if (any_rise) cnt <= delay;
        WAIT_VALID: if (valid && !cnt_zero) cnt <= cnt - CNT_WIDTH'(1);
        DELAY:      if (!cnt_zero) cnt <= cnt - CNT_WIDTH'(1);
        FIRE:       if (holdoff != {CNT_WIDTH{1'b0}}) cnt <= holdoff - CNT_WIDTH'(1);
        HOLDOFF:    if (!cnt_zero) cnt <= cnt - CNT_WIDTH'(1);
        default:    cnt <= cnt;
      endcase
    end
  end

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:       next_state = arm ? ARMED : IDLE;
        ARMED:      next_state = any_rise ? WAIT_VALID : ARMED;
        WAIT_VALID: begin
          if (valid) begin
            next_state = cnt_zero ? FIRE : DELAY;
          end else begin
            next_state = WAIT_VALID;
          end
        end
        DELAY:      next_state = cnt_zero ? FIRE : DELAY;
        FIRE: begin
          if (holdoff == {CNT_WIDTH{1'b0}}) begin
            next_state = mode_continuous ? ARMED : IDLE;
          end else begin
            next_state = HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (cnt_zero) begin
            next_state = mode_continuous ? ARMED : IDLE;
          end else begin
            next_state = HOLDOFF;
          end
        end
        default:    next_state = IDLE;
      endcase
    end
  end

  // Status decodes of the registered state.
  always_comb begin
    armed = (state == ARMED);
    busy  = (state != IDLE);
  end

endmodule

// File: tb/tb_trig_sequencer.sv
// Self-checking bench for trig_sequencer: expected pulses (cycle, source) are queued
// when stimulus is driven and matched by a monitor whenever trig_out is seen high.
module tb_trig_sequencer;

  logic        clk = 1'b0;
  logic        resetn, arm, abort, mode_continuous, valid;
  logic [3:0]  src_mask, trig_in;
  logic [15:0] delay, holdoff;
  logic        trig_out, armed, busy;
  logic [1:0]  src_id;
  logic [31:0] trig_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_cyc[$];
  int exp_src[$];

  trig_sequencer #(.N_SRC(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .arm(arm), .abort(abort),
    .mode_continuous(mode_continuous), .src_mask(src_mask), .trig_in(trig_in),
    .valid(valid), .delay(delay), .holdoff(holdoff), .trig_out(trig_out),
    .src_id(src_id), .armed(armed), .busy(busy), .trig_count(trig_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every observed pulse must match the oldest expected one.
  always @(negedge clk) begin
    int ec, es;
    if (trig_out === 1'b1) begin
      n_cmp++;
      if (exp_cyc.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse: trig_out=1 at cycle %0d, required no pulse", cyc);
      end else begin
        ec = exp_cyc.pop_front();
        es = exp_src.pop_front();
        if (cyc !== ec || int'(src_id) !== es) begin
          n_err++;
          $display("FAIL pulse: got cycle %0d src_id %0d, required cycle %0d src_id %0d",
                   cyc, src_id, ec, es);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_fire(input int c, input int s);
    exp_cyc.push_back(c);
    exp_src.push_back(s);
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_cyc.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    n_cmp++;
    if (exp_cyc.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d pulses outstanding, required 0", exp_cyc.size());
      exp_cyc.delete();
      exp_src.delete();
    end
  endtask

  task automatic arm_seq();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_cmp++;
    if ({trig_out, armed, busy} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: trig_out/armed/busy=%b, required 000", {trig_out, armed, busy});
    end
    n_cmp++;
    if (src_id !== 2'd0 || trig_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_regs: src_id=%0d trig_count=%0d, required 0 0", src_id, trig_count);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_basic_one_shot();
    int vs;
    src_mask = 4'b0001; delay = 16'd0; holdoff = 16'd0; mode_continuous = 1'b0;
    valid = 1'b0; trig_in = 4'b0000;
    arm_seq();
    repeat (3) tick();
    trig_in[0] = 1'b1;
    repeat (10) tick();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || armed !== 1'b0) begin
      n_err++;
      $display("FAIL wait_valid_status: busy=%b armed=%b, required 1 0", busy, armed);
    end
    tick();
    valid = 1'b1;
    vs = cyc;
    expect_fire(vs + 1, 0);
    wait_drain(20);
    tick();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || trig_out !== 1'b0 || trig_count !== 32'd1 || src_id !== 2'd0) begin
      n_err++;
      $display("FAIL one_shot_end: busy=%b trig_out=%b count=%0d src=%0d, required 0 0 1 0",
               busy, trig_out, trig_count, src_id);
    end
    valid = 1'b0;
    trig_in = 4'b0000;
    tick();
  endtask

  task automatic test_delay_prevalid();
    int c;
    delay = 16'd5; valid = 1'b1;
    arm_seq();
    tick();
    trig_in[0] = 1'b1;
    c = cyc;
    expect_fire(c + 7, 0);
    tick();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || armed !== 1'b0) begin
      n_err++;
      $display("FAIL accept_latency: busy=%b armed=%b at c+1, required 1 0", busy, armed);
    end
    wait_drain(30);
    tick();
    @(negedge clk);
    n_cmp++;
    if (trig_count !== 32'd2 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL delay_end: count=%0d busy=%b, required 2 0", trig_count, busy);
    end
    trig_in = 4'b0000;
    tick();
  endtask

  task automatic test_arbitration();
    int c;
    src_mask = 4'b1110; delay = 16'd0; valid = 1'b1;
    arm_seq();
    tick();
    trig_in = 4'b1010;
    c = cyc;
    expect_fire(c + 2, 1);
    wait_drain(20);
    trig_in = 4'b0000;
    repeat (3) tick();
    arm_seq();
    tick();
    trig_in = 4'b0001;
    repeat (10) tick();
    @(negedge clk);
    n_cmp++;
    if (armed !== 1'b1 || trig_count !== 32'd3 || src_id !== 2'd1) begin
      n_err++;
      $display("FAIL masked_src: armed=%b count=%0d src=%0d, required 1 3 1",
               armed, trig_count, src_id);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    trig_in = 4'b0000;
    tick();
  endtask

  task automatic test_continuous_holdoff();
    int armed_from, nexp, e;
    logic [31:0] cnt0;
    src_mask = 4'b0001; delay = 16'd2; holdoff = 16'd8; mode_continuous = 1'b1;
    valid = 1'b1; trig_in = 4'b0000;
    cnt0 = trig_count;
    nexp = 0;
    arm = 1'b1;
    armed_from = cyc + 1;
    tick();
    arm = 1'b0;
    repeat (2) tick();
    for (int k = 0; k < 64; k++) begin
      tick();
      if (k % 4 == 0) begin
        trig_in[0] = ~trig_in[0];
        if (trig_in[0] == 1'b1) begin
          e = cyc;
          if (e >= armed_from) begin
            expect_fire(e + 4, 0);
            armed_from = e + 4 + 8 + 1;
            nexp++;
          end
        end
      end
    end
    trig_in = 4'b0000;
    wait_drain(40);
    repeat (12) tick();
    @(negedge clk);
    n_cmp++;
    if (trig_count !== cnt0 + 32'(nexp) || armed !== 1'b1) begin
      n_err++;
      $display("FAIL continuous_count: count=%0d armed=%b, required %0d 1",
               trig_count, armed, cnt0 + 32'(nexp));
    end
    mode_continuous = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    holdoff = 16'd0;
    tick();
  endtask

  task automatic test_abort();
    int c;
    logic [31:0] cnt0;
    src_mask = 4'b0001; delay = 16'd100; valid = 1'b1; trig_in = 4'b0000;
    cnt0 = trig_count;
    arm_seq();
    tick();
    trig_in[0] = 1'b1;
    repeat (10) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || trig_out !== 1'b0 || trig_count !== cnt0 || src_id !== 2'd0) begin
      n_err++;
      $display("FAIL abort_delay: busy=%b trig_out=%b count=%0d src=%0d, required 0 0 %0d 0",
               busy, trig_out, trig_count, src_id, cnt0);
    end
    arm = 1'b1; abort = 1'b1;
    tick();
    arm = 1'b0; abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || armed !== 1'b0) begin
      n_err++;
      $display("FAIL arm_abort: busy=%b armed=%b, required 0 0", busy, armed);
    end
    // Abort sampled in FIRE: pulse still seen, count must not advance.
    trig_in = 4'b0000; delay = 16'd0;
    arm_seq();
    tick();
    trig_in[0] = 1'b1;
    c = cyc;
    expect_fire(c + 2, 0);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (trig_count !== cnt0 || busy !== 1'b0 || trig_out !== 1'b0) begin
      n_err++;
      $display("FAIL abort_fire: count=%0d busy=%b trig_out=%b, required %0d 0 0",
               trig_count, busy, trig_out, cnt0);
    end
    wait_drain(5);
    trig_in = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_delay();
    int c;
    src_mask = 4'b0010; delay = 16'd100; valid = 1'b1; trig_in = 4'b0000;
    arm_seq();
    tick();
    trig_in = 4'b0011;
    repeat (10) tick();
    @(negedge clk);
    n_cmp++;
    if (src_id !== 2'd1 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset: src=%0d busy=%b, required 1 1", src_id, busy);
    end
    resetn = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if ({trig_out, armed, busy} !== 3'b000 || src_id !== 2'd0 || trig_count !== 32'd0) begin
      n_err++;
      $display("FAIL mid_reset: flags=%b src=%0d count=%0d, required 000 0 0",
               {trig_out, armed, busy}, src_id, trig_count);
    end
    resetn = 1'b1;
    src_mask = 4'b0001; delay = 16'd0;
    trig_in = 4'b0001;
    tick();
    arm_seq();
    repeat (10) tick();
    @(negedge clk);
    n_cmp++;
    if (armed !== 1'b1 || trig_count !== 32'd0) begin
      n_err++;
      $display("FAIL held_high: armed=%b count=%0d, required 1 0", armed, trig_count);
    end
    trig_in[0] = 1'b0;
    tick();
    trig_in[0] = 1'b1;
    c = cyc;
    expect_fire(c + 2, 0);
    wait_drain(20);
    tick();
    @(negedge clk);
    n_cmp++;
    if (trig_count !== 32'd1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_fire: count=%0d busy=%b, required 1 0", trig_count, busy);
    end
  endtask

  initial begin
    resetn = 1'b0; arm = 1'b0; abort = 1'b0; mode_continuous = 1'b0; valid = 1'b0;
    src_mask = 4'b0000; trig_in = 4'b0000; delay = 16'd0; holdoff = 16'd0;
    test_reset();
    test_basic_one_shot();
    test_delay_prevalid();
    test_arbitration();
    test_continuous_holdoff();
    test_abort();
    test_reset_mid_delay();
    repeat (5) tick();
    n_cmp++;
    if (exp_cyc.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d pulses outstanding, required 0", exp_cyc.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
